// File: rtl/ads127l01_fsync_rx.sv
// ads127l01_fsync_rx: frame-sync serial receiver for the ADS127L01 ADC.
// Oversamples sck/dout/fsync in the clk domain, assembles 24-bit MSB-first
// samples and queues them in a FIFO drained through an AXI-Stream-like port.
// Optional feature macro ADS_RX_SEQ_EN: when defined, tdata[31:24] carries an
// 8-bit frame sequence number; otherwise it is the sign extension of bit 23.
module ads127l01_fsync_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          sck,
  input  logic                          dout,
  input  logic                          fsync,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   rd_cnt,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_FS = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;
  localparam logic [1:0] PUSH    = 2'd3;

  // Synchronizer chains plus one history flop for edge detection.
  logic [SYNC_STAGES-1:0] sck_sync_q, dout_sync_q, fs_sync_q;
  logic                   sck_prev_q, fs_prev_q;
  logic                   sck_s, dout_s, fs_s, sck_rise, fs_rise;

  // FSM and shifter state.
  logic [1:0]  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        frame_err_q, frame_err_d;

  // FIFO state.
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          overflow_q;
  logic          push, pop, full, wr_en;
  logic [31:0]   push_word;

  // Bring the asynchronous ADC pins into the clk domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      dout_sync_q <= '0;
      fs_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
      fs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      dout_sync_q <= {dout_sync_q[SYNC_STAGES-2:0], dout};
      fs_sync_q   <= {fs_sync_q[SYNC_STAGES-2:0], fsync};
      sck_prev_q  <= sck_s;
      fs_prev_q   <= fs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign dout_s   = dout_sync_q[SYNC_STAGES-1];
  assign fs_s     = fs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign fs_rise  = fs_s & ~fs_prev_q;

  // Frame FSM: wait for fsync, shift 24 bits, hand the word to the FIFO.
  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    if (!en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE:    state_d = WAIT_FS;
        WAIT_FS: begin
          if (fs_rise) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
          end
        end
        SHIFT: begin
          if (fs_rise) begin
            // A new frame started before this one completed: drop it, restart.
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            shift_d     = '0;
          end else if (sck_rise) begin
            shift_d   = {shift_q[22:0], dout_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) state_d = PUSH;
          end
        end
        PUSH:    state_d = WAIT_FS;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, shifter and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef ADS_RX_SEQ_EN
  logic [7:0] seq_q;

  // Frame sequence number, advanced for every completed frame, kept or dropped.
  always_ff @(posedge clk) begin
    if (rst)       seq_q <= '0;
    else if (push) seq_q <= seq_q + 8'd1;
  end

  assign push_word = {seq_q, shift_q};
`else
  assign push_word = {{8{shift_q[23]}}, shift_q};
`endif

  assign push  = (state_q == PUSH);
  assign pop   = m_axis_tvalid & m_axis_tready;
  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign wr_en = push & (~full | pop);

  // Fill level: a simultaneous write and read leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
  end

  // FIFO pointers, fill count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_q | (push & full & ~pop);
    end
  end

  // Sample storage.
  // NOTE: the array is deliberately not reset; validity is tracked by the
  // pointers and count, and the output is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_word;
  end

  assign m_axis_tvalid = (cnt_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : 32'd0;
  assign rd_cnt        = cnt_q;
  assign overflow      = overflow_q;
  assign frame_err     = frame_err_q;

endmodule

// File: doc/ads127l01_fsync_rx.md
ADS127L01_FSYNC_RX -- requirements
Module: ads127l01_fsync_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: sample FIFO depth in words; power of 2, range 4..256.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on sck/dout/fsync; range 2..3.
REQ-003 SHALL have port clk, input, 1: the single clock; sck frequency ≤ clk/4.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1: receiver enable; level-sensitive.
REQ-006 SHALL have port sck, input, 1: ADC serial clock, asynchronous to clk.
REQ-007 SHALL have port dout, input, 1: ADC serial data, MSB first, changes on sck falling edge.
REQ-008 SHALL have port fsync, input, 1: ADC frame sync, high marks a new frame.
REQ-009 SHALL have port m_axis_tdata, output, 32: received sample word.
REQ-010 SHALL have port m_axis_tvalid, output, 1: sample available.
REQ-011 SHALL have port m_axis_tready, input, 1: consumer accepts the word.
REQ-012 SHALL have port rd_cnt, output, $clog2(FIFO_DEPTH)+1: FIFO fill level.
REQ-013 SHALL have port overflow, output, 1: sticky flag, sample dropped because the FIFO was full.
REQ-014 SHALL have port frame_err, output, 1: single-cycle pulse on a truncated frame.

Function
REQ-015 SHALL pass sck, dout and fsync through SYNC_STAGES flops; all edge detection SHALL use synchronized signals only.
REQ-016 SHALL use states IDLE, WAIT_FS, SHIFT and PUSH.
REQ-017 IDLE: entered while en=0; bit counter cleared, shift register held; leaves to WAIT_FS when en=1.
REQ-018 WAIT_FS: leaves to SHIFT on a synchronized fsync rising edge; if en rises mid-frame, the partial frame SHALL be ignored until the next fsync rise.
REQ-019 SHALL, in SHIFT, capture dout on each synchronized sck rising edge into bit 23..0 (MSB first); after the 24th capture the state SHALL go to PUSH.
REQ-020 SHALL, in PUSH (one clk cycle), write the 24-bit word to the FIFO when not full, else drop it and set overflow; the state SHALL then return to WAIT_FS.
REQ-021 SHALL, on an fsync rising edge in SHIFT with fewer than 24 bits captured, pulse frame_err for 1 cycle, discard the partial word and restart SHIFT with a zero bit count.
REQ-022 SHALL, when en falls, return to IDLE on the next cycle and discard any partial word; FIFO contents SHALL be kept and stay readable.
REQ-023 A word SHALL be readable with m_axis_tvalid=1 no later than 2 clk cycles after the PUSH cycle when the FIFO was empty.
REQ-024 m_axis_tdata SHALL be the FIFO head; a pop SHALL occur on a cycle with m_axis_tvalid=1 and m_axis_tready=1.
REQ-025 m_axis_tvalid SHALL be equal to (rd_cnt != 0); tdata SHALL stay stable while tvalid=1 and tready=0.
REQ-026 Simultaneous push and pop SHALL leave rd_cnt unchanged; push to a full FIFO with a pop in the same cycle SHALL succeed.
REQ-027 rd_cnt SHALL saturate at FIFO_DEPTH; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 overflow SHALL stay set until rst; reading SHALL NOT clear it.

Reset
REQ-029 SHALL, on a cycle with rst=1, set the state to IDLE and clear the bit counter, shift register, FIFO pointers and synchronizer flops.
REQ-030 SHALL drive m_axis_tvalid=0, m_axis_tdata=0, rd_cnt=0, overflow=0 and frame_err=0 during and after reset until new data arrives.
REQ-031 rst asserted mid-frame SHALL discard the frame with no frame_err; reception SHALL resume only at a fsync rise after rst deassertion.

Configuration
REQ-032 With ADS_RX_SEQ_EN defined, m_axis_tdata[31:24] SHALL carry an 8-bit frame sequence number.
REQ-033 The sequence number SHALL increment per PUSH (including dropped samples), wrap 255->0 and clear on rst.
REQ-034 Without ADS_RX_SEQ_EN, m_axis_tdata[31:24] SHALL be the sign extension of bit 23 and no sequence counter SHALL exist.

Verification
REQ-035 Bench SHALL cover: en=1, one frame 24'h800001, tready=1 -> tdata=32'hFF800001 (no macro), tvalid 1-cycle pulse, rd_cnt returns 0.
REQ-036 Bench SHALL cover: 16 frames 24'h000000..24'h00000F with tready=0 then a 17th frame -> rd_cnt=16, overflow=1; draining yields 0..F in order.
REQ-037 Bench SHALL cover: fsync re-asserted after 10 bits, followed by a full frame 24'h123456 -> one frame_err pulse, only 32'h00123456 delivered.
REQ-038 Bench SHALL cover: en dropped after 12 bits, restored mid-frame, then a full frame 24'h7FFFFF -> no partial word, next word 32'h007FFFFF.
REQ-039 Bench SHALL cover: ADS_RX_SEQ_EN defined, 257 frames of 24'h000001 drained -> tdata[31:24] runs 0..255,0 and tdata[23:0] is 24'h000001 in every word.
REQ-040 Bench SHALL cover: rst pulse after 20 bits, then a frame 24'hABCDEF -> no frame_err, single word 32'hFFABCDEF.
